// File: rtl/req_ack_scheduler_if.sv
// Handshake bundle between a group of requesters, the shared resource and the
// req_ack_scheduler. The scheduler connects through the slave modport; the
// environment (requesters plus resource model) drives through the master one.
interface req_ack_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 8
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  req;          // per-requester request level
    logic             res_ack;      // acknowledge from the shared resource
    logic             res_req;      // one-cycle request pulse to the resource
    logic [ID_W-1:0]  res_id;       // requester currently being served
    logic [NREQ-1:0]  done;         // one-hot completion pulse
    logic             err_timeout;  // one-cycle timeout pulse
    logic             busy;         // scheduler is not idle
    logic [CNT_W-1:0] req_cnt;      // accepted requests (wrapping)
    logic [CNT_W-1:0] ack_cnt;      // accepted acknowledges (wrapping)
    logic             stray_ack;    // sticky: ack seen outside WAIT

    // Scheduler side.
    modport slave (
        input  req,
        input  res_ack,
        output res_req,
        output res_id,
        output done,
        output err_timeout,
        output busy,
        output req_cnt,
        output ack_cnt,
        output stray_ack
    );

    // Requesters / resource side.
    modport master (
        output req,
        output res_ack,
        input  res_req,
        input  res_id,
        input  done,
        input  err_timeout,
        input  busy,
        input  req_cnt,
        input  ack_cnt,
        input  stray_ack
    );
endinterface

// File: rtl/req_ack_scheduler.sv
// Round-robin scheduler that shares one req/ack resource among NREQ
// requesters. Requests are captured on rising edges of the req levels, held
// as pending bits, granted one at a time, and each grant is closed either by
// res_ack (done pulse) or by a TIMEOUT-cycle watchdog (err_timeout pulse).
module req_ack_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 7,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    req_ack_scheduler_if.slave bus
);
    localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    // FSM encoding kept as plain constants so the state vector can be probed
    // and compared directly in legacy tooling.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [1:0]       state_q,   state_d;
    logic [ID_W-1:0]  rr_q,      rr_d;
    logic [NREQ-1:0]  pending_q, pending_d;
    logic [NREQ-1:0]  req_q;
    logic             primed_q;
    logic [TMR_W-1:0] timer_q,   timer_d;
    logic [ID_W-1:0]  res_id_q,  res_id_d;
    logic [NREQ-1:0]  done_q,    done_d;
    logic             err_q,     err_d;
    logic [CNT_W-1:0] req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d;
    logic             stray_q,   stray_d;

    // ------------------------------------------------------------------
    // Per-requester edge detection and acceptance
    // ------------------------------------------------------------------
    logic [NREQ-1:0]  rise;
    logic [NREQ-1:0]  accept;
    logic [NREQ-1:0]  id_match;
    logic [CNT_W-1:0] accept_cnt;

    // req_q is cleared by reset, so a level that is already high when reset
    // releases would look like a fresh rise. primed_q masks rise detection on
    // the first edge after reset so such a level is only latched, not counted.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign rise[gi]     = bus.req[gi] & ~req_q[gi] & primed_q;
            assign accept[gi]   = rise[gi] & ~pending_q[gi];
            assign id_match[gi] = (res_id_q == ID_W'(gi));
        end
    endgenerate

    // Number of requests accepted on this edge (several may rise together).
    always_comb begin
        accept_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            accept_cnt = accept_cnt + CNT_W'(accept[i]);
        end
    end

    // ------------------------------------------------------------------
    // Round-robin selection: first pending bit at or after rr, wrapping.
    // Scanning offsets from high to low lets the lowest offset win last.
    // ------------------------------------------------------------------
    logic            grant_valid;
    logic [ID_W-1:0] grant_id;
    logic [ID_W:0]   cand;

    // Pick the winner among pending requesters starting at the rr pointer.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            cand = {1'b0, rr_q} + (ID_W + 1)'(off);
            if (cand >= (ID_W + 1)'(NREQ)) begin
                cand = cand - (ID_W + 1)'(NREQ);
            end
            if (pending_q[cand[ID_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_id    = cand[ID_W-1:0];
            end
        end
    end

    // Pointer value that follows the requester just served.
    logic [ID_W-1:0] next_rr;
    assign next_rr = (res_id_q == ID_W'(NREQ - 1)) ? '0 : res_id_q + ID_W'(1);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // FSM, pending bookkeeping, counters and pulse generation.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        timer_d   = timer_q;
        res_id_d  = res_id_q;
        ack_cnt_d = ack_cnt_q;
        stray_d   = stray_q;
        done_d    = '0;
        err_d     = 1'b0;

        // New rises become pending; rises on an already pending requester
        // are dropped by the accept mask.
        pending_d = pending_q | accept;
        req_cnt_d = req_cnt_q + accept_cnt;

        // Any acknowledge outside WAIT is unexpected and only flagged.
        if (bus.res_ack && (state_q != ST_WAIT)) begin
            stray_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    res_id_d            = grant_id;
                    pending_d[grant_id] = 1'b0;
                    state_d             = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                // An ack on the last allowed cycle still completes normally.
                if (bus.res_ack) begin
                    state_d   = ST_IDLE;
                    done_d    = id_match;
                    ack_cnt_d = ack_cnt_q + CNT_W'(1);
                    rr_d      = next_rr;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                    if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                        rr_d    = next_rr;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers with asynchronous active-low reset
    // ------------------------------------------------------------------
    // Reset abandons any transaction in flight: no done or err pulse follows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_q      <= '0;
            pending_q <= '0;
            req_q     <= '0;
            primed_q  <= 1'b0;
            timer_q   <= '0;
            res_id_q  <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            req_cnt_q <= '0;
            ack_cnt_q <= '0;
            stray_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            pending_q <= pending_d;
            req_q     <= bus.req;
            primed_q  <= 1'b1;
            timer_q   <= timer_d;
            res_id_q  <= res_id_d;
            done_q    <= done_d;
            err_q     <= err_d;
            req_cnt_q <= req_cnt_d;
            ack_cnt_q <= ack_cnt_d;
            stray_q   <= stray_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // res_req and busy decode the state directly so both drop the moment
    // reset is applied.
    assign bus.res_req     = (state_q == ST_ISSUE);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.res_id      = res_id_q;
    assign bus.done        = done_q;
    assign bus.err_timeout = err_q;
    assign bus.req_cnt     = req_cnt_q;
    assign bus.ack_cnt     = ack_cnt_q;
    assign bus.stray_ack   = stray_q;

endmodule

// File: tb/tb_req_ack_scheduler.sv
// Directed bench for req_ack_scheduler: single request, contention order,
// timeout, ack-on-last-cycle boundary, drop/stray handling, counter wrap and
// reset in the middle of a transaction.
module tb_req_ack_scheduler;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 7;
    localparam int CNT_W   = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    req_ack_scheduler_if #(.NREQ(NREQ), .CNT_W(CNT_W)) bus ();

    req_ack_scheduler #(
        .NREQ   (NREQ),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, ".res_req"},     32'(bus.res_req),     32'd0);
        check_val({tag, ".res_id"},      32'(bus.res_id),      32'd0);
        check_val({tag, ".done"},        32'(bus.done),        32'd0);
        check_val({tag, ".err_timeout"}, 32'(bus.err_timeout), 32'd0);
        check_val({tag, ".busy"},        32'(bus.busy),        32'd0);
        check_val({tag, ".req_cnt"},     32'(bus.req_cnt),     32'd0);
        check_val({tag, ".ack_cnt"},     32'(bus.ack_cnt),     32'd0);
        check_val({tag, ".stray_ack"},   32'(bus.stray_ack),   32'd0);
    endtask

    // Asynchronous reset away from the edge, then one priming edge.
    task automatic do_reset(input string tag);
        bus.res_ack = 1'b0;
        rst_n = 1'b0;
        #2;
        check_all_zero(tag);
        step();
        rst_n = 1'b1;
        step();
        $display("reset %s done", tag);
    endtask

    // Called just after the ISSUE edge; acks on WAIT edge n and checks done.
    task automatic serve(input int id, input int n);
        check_val("serve.res_id", 32'(bus.res_id), 32'(id));
        check_val("serve.res_req", 32'(bus.res_req), 32'd1);
        step();
        check_val("serve.res_req_drop", 32'(bus.res_req), 32'd0);
        check_val("serve.busy_wait", 32'(bus.busy), 32'd1);
        for (int w = 1; w < n; w++) step();
        bus.res_ack = 1'b1;
        step();
        bus.res_ack = 1'b0;
        check_val("serve.done", 32'(bus.done), 32'd1 << id);
        check_val("serve.no_err", 32'(bus.err_timeout), 32'd0);
        check_val("serve.idle", 32'(bus.busy), 32'd0);
        $display("txn: requester %0d acked on wait edge %0d, ack_cnt=%0d", id, n, bus.ack_cnt);
    endtask

    initial begin
        bus.req     = '0;
        bus.res_ack = 1'b0;
        #1;
        do_reset("initial");

        // Single request: ack two cycles after res_req.
        bus.req = 4'b0001;
        step();
        check_val("single.req_cnt", 32'(bus.req_cnt), 32'd1);
        check_val("single.not_yet", 32'(bus.res_req), 32'd0);
        step();
        serve(0, 2);
        check_val("single.ack_cnt", 32'(bus.ack_cnt), 32'd1);
        bus.req = 4'b0000;
        step();
        check_val("single.done_clear", 32'(bus.done), 32'd0);

        // Contention: all four rise together, expect order 0,1,2,3.
        do_reset("contention");
        bus.req = 4'b1111;
        step();
        check_val("cont.req_cnt", 32'(bus.req_cnt), 32'd4);
        step();
        for (int id = 0; id < NREQ; id++) begin
            serve(id, 1);
            step();
        end
        check_val("cont.req_cnt_end", 32'(bus.req_cnt), 32'd4);
        check_val("cont.ack_cnt_end", 32'(bus.ack_cnt), 32'd4);
        check_val("cont.done_clear", 32'(bus.done), 32'd0);

        // Levels held through reset must not count as rises.
        do_reset("held");
        step();
        step();
        check_val("held.req_cnt", 32'(bus.req_cnt), 32'd0);
        check_val("held.busy", 32'(bus.busy), 32'd0);

        // Timeout on requester 2.
        bus.req = 4'b0000;
        step();
        bus.req = 4'b0100;
        step();
        step();
        check_val("tmo.res_id", 32'(bus.res_id), 32'd2);
        check_val("tmo.res_req", 32'(bus.res_req), 32'd1);
        step();
        for (int w = 1; w < TIMEOUT; w++) begin
            step();
            check_val("tmo.no_err_early", 32'(bus.err_timeout), 32'd0);
            check_val("tmo.busy_early", 32'(bus.busy), 32'd1);
        end
        step();
        check_val("tmo.err", 32'(bus.err_timeout), 32'd1);
        check_val("tmo.no_done", 32'(bus.done), 32'd0);
        check_val("tmo.idle", 32'(bus.busy), 32'd0);
        check_val("tmo.ack_cnt", 32'(bus.ack_cnt), 32'd0);
        $display("txn: requester 2 timed out after %0d wait edges", TIMEOUT);
        step();
        check_val("tmo.err_clear", 32'(bus.err_timeout), 32'd0);
        check_val("tmo.res_id_hold", 32'(bus.res_id), 32'd2);

        // Boundary: ack on the last allowed wait edge; rr now points at 3.
        bus.req = 4'b0000;
        step();
        bus.req = 4'b1000;
        step();
        step();
        serve(3, TIMEOUT);
        check_val("bound.ack_cnt", 32'(bus.ack_cnt), 32'd1);
        check_val("bound.req_cnt", 32'(bus.req_cnt), 32'd2);

        // Stray ack in IDLE.
        check_val("stray.before", 32'(bus.stray_ack), 32'd0);
        bus.res_ack = 1'b1;
        step();
        bus.res_ack = 1'b0;
        check_val("stray.set", 32'(bus.stray_ack), 32'd1);
        check_val("stray.no_done", 32'(bus.done), 32'd0);
        check_val("stray.ack_cnt", 32'(bus.ack_cnt), 32'd1);
        $display("txn: stray ack in idle flagged");

        // Drop: req[1] rises again while still pending behind requester 0.
        bus.req = 4'b0000;
        step();
        bus.req = 4'b0011;
        step();
        check_val("drop.req_cnt_two", 32'(bus.req_cnt), 32'd4);
        step();
        check_val("drop.first_id", 32'(bus.res_id), 32'd0);
        bus.req = 4'b0001;
        step();
        bus.req = 4'b0011;
        step();
        check_val("drop.req_cnt_same", 32'(bus.req_cnt), 32'd4);
        bus.res_ack = 1'b1;
        step();
        bus.res_ack = 1'b0;
        check_val("drop.done0", 32'(bus.done), 32'd1);
        $display("txn: requester 0 acked, duplicate rise of requester 1 dropped");
        step();
        serve(1, 1);
        check_val("drop.ack_cnt", 32'(bus.ack_cnt), 32'd3);
        step();
        check_val("drop.idle", 32'(bus.busy), 32'd0);
        check_val("drop.stray_sticky", 32'(bus.stray_ack), 32'd1);

        // Counter wrap: 256 single requests, each acked on the first wait edge.
        bus.req = 4'b0000;
        do_reset("wrap");
        bus.res_ack = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.req = 4'b0001;
            step();
            bus.req = 4'b0000;
            repeat (4) step();
            if (i == 254) begin
                check_val("wrap.req_cnt_255", 32'(bus.req_cnt), 32'd255);
                check_val("wrap.ack_cnt_255", 32'(bus.ack_cnt), 32'd255);
            end
        end
        bus.res_ack = 1'b0;
        check_val("wrap.req_cnt", 32'(bus.req_cnt), 32'd0);
        check_val("wrap.ack_cnt", 32'(bus.ack_cnt), 32'd0);
        check_val("wrap.idle", 32'(bus.busy), 32'd0);
        $display("txn: 256 requests served, counters wrapped");

        // Reset asserted mid-WAIT for requester 1 (rr=1 after serving 0).
        bus.req = 4'b0010;
        step();
        step();
        check_val("mid.res_id", 32'(bus.res_id), 32'd1);
        step();
        step();
        check_val("mid.busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #2;
        check_all_zero("mid_reset");
        repeat (3) step();
        check_all_zero("mid_held");
        rst_n = 1'b1;
        for (int i = 0; i < 2 * TIMEOUT; i++) begin
            step();
            check_val("mid.quiet", {29'd0, bus.err_timeout, |bus.done, bus.busy}, 32'd0);
        end
        $display("txn: reset mid-wait abandoned requester 1");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
